// File: rtl/id_reg_file.sv
// Decode-stage integer register file: 32 x 32-bit registers with a per-register
// pending-write scoreboard bit. x0 reads as zero and is never pending.
module id_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1,
    output logic [31:0] src1,
    output logic        modi1,
    input  logic [4:0]  rd,
    input  logic [4:0]  reg_write,
    input  logic [31:0] data_write
);

    logic [31:0] regs     [0:31];
    logic        modified [0:31];

    // Register and scoreboard update; reset clears everything and overrides writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i]     <= 32'd0;
                modified[i] <= 1'b0;
            end
        end else begin
            if (reg_write != 5'd0) begin
                regs[reg_write]     <= data_write;
                modified[reg_write] <= 1'b0;
            end
            // Issued on the same edge as write-back: the new producer keeps it pending
            if (rd != 5'd0) begin
                modified[rd] <= 1'b1;
            end
        end
    end

    // Combinational operand read, no write-through bypass
    always_comb begin
        src1  = 32'd0;
        modi1 = 1'b0;
        if (rs1 == 5'd0) begin
            src1  = 32'd0;
            modi1 = 1'b0;
        end else begin
            src1  = regs[rs1];
            modi1 = modified[rs1];
        end
    end

endmodule

// File: tb/tb_id_reg_file.sv
// Directed self-checking bench for id_reg_file with hand-computed expectations.
module tb_id_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1;
    logic [31:0] src1;
    logic        modi1;
    logic [4:0]  rd;
    logic [4:0]  reg_write;
    logic [31:0] data_write;

    int checks_r;
    int errors_r;

    id_reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .rs1        (rs1),
        .src1       (src1),
        .modi1      (modi1),
        .rd         (rd),
        .reg_write  (reg_write),
        .data_write (data_write)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_r   = 0;
        errors_r   = 0;
        rst        = 1'b1;
        rs1        = 5'd5;
        rd         = 5'd0;
        reg_write  = 5'd5;
        data_write = 32'h0000_00FF;
        step();
        step();

        // Reset state
        rst       = 1'b0;
        reg_write = 5'd0;
        #1;
        check_val("rst_src1", src1, 32'd0);
        check_val("rst_modi1", {31'd0, modi1}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check_val($sformatf("rst_regs%0d", i), dut.regs[i], 32'd0);
            check_val($sformatf("rst_mod%0d", i), {31'd0, dut.modified[i]}, 32'd0);
        end

        // Write-back sweep, then an attempted write to x0
        for (int i = 1; i < 32; i++) begin
            reg_write  = 5'(i);
            data_write = 32'(i);
            step();
        end
        reg_write  = 5'd0;
        data_write = 32'hDEAD_BEEF;
        step();
        check_val("wr_regs0", dut.regs[0], 32'd0);
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check_val($sformatf("wr_src1_%0d", i), src1, 32'(i));
            check_val($sformatf("wr_modi1_%0d", i), {31'd0, modi1}, 32'd0);
        end
        rs1 = 5'd0;
        #1;
        check_val("x0_src1", src1, 32'd0);

        // Pending set
        for (int i = 1; i < 32; i++) begin
            rd = 5'(i);
            step();
        end
        rd = 5'd0;
        step();
        check_val("pend_mod0", {31'd0, dut.modified[0]}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check_val($sformatf("pend_modi1_%0d", i), {31'd0, modi1}, 32'd1);
        end

        // Pending clear via write-back
        for (int i = 1; i < 32; i++) begin
            reg_write  = 5'(i);
            data_write = 32'(i);
            step();
        end
        reg_write = 5'd0;
        for (int i = 1; i < 32; i++) begin
            check_val($sformatf("clr_mod%0d", i), {31'd0, dut.modified[i]}, 32'd0);
            check_val($sformatf("clr_regs%0d", i), dut.regs[i], 32'(i));
        end

        // Simultaneous rd == reg_write: data written, pending stays set
        rd         = 5'd7;
        reg_write  = 5'd7;
        data_write = 32'h0000_1234;
        step();
        check_val("sim_regs7", dut.regs[7], 32'h0000_1234);
        check_val("sim_mod7", {31'd0, dut.modified[7]}, 32'd1);

        // Different rd and reg_write apply independently
        rd         = 5'd3;
        reg_write  = 5'd7;
        data_write = 32'h0000_5678;
        step();
        check_val("ind_mod3", {31'd0, dut.modified[3]}, 32'd1);
        check_val("ind_mod7", {31'd0, dut.modified[7]}, 32'd0);
        check_val("ind_regs7", dut.regs[7], 32'h0000_5678);
        check_val("ind_regs3", dut.regs[3], 32'd3);
        rd        = 5'd0;
        reg_write = 5'd0;

        // No bypass: old value visible until the edge
        rs1        = 5'd9;
        reg_write  = 5'd9;
        data_write = 32'h0000_ABCD;
        #1;
        check_val("byp_before", src1, 32'd9);
        step();
        check_val("byp_after", src1, 32'h0000_ABCD);

        // Held reg_write re-applies; rd on the same register keeps it pending
        rd = 5'd9;
        step();
        check_val("hold_pend", {31'd0, modi1}, 32'd1);
        rd = 5'd0;
        step();
        check_val("hold_clr", {31'd0, modi1}, 32'd0);
        reg_write = 5'd0;

        // Mid-operation reset overrides simultaneous write and rd
        rst        = 1'b1;
        rd         = 5'd4;
        reg_write  = 5'd4;
        data_write = 32'h0000_0077;
        step();
        rst       = 1'b0;
        rd        = 5'd0;
        reg_write = 5'd0;
        check_val("mrst_regs4", dut.regs[4], 32'd0);
        check_val("mrst_mod4", {31'd0, dut.modified[4]}, 32'd0);
        check_val("mrst_regs9", dut.regs[9], 32'd0);
        check_val("mrst_mod3", {31'd0, dut.modified[3]}, 32'd0);
        check_val("mrst_src1", src1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/id_reg_file.md
# id_reg_file

Architectural integer register file for the decode (ID) stage: 32 registers × 32 bits, plus a per-register "modified" (pending-write) scoreboard bit. Decode reads one source operand and its pending flag combinationally, marks the destination of an issuing instruction as pending, and write-back stores results and clears the pending flag. Register x0 is hardwired to zero and is never pending.

## Interface

Parameters: none. Widths are fixed by the codebase defines: `REG_NUM` = 5-bit register index, `COMMON_WIDTH` = 32-bit data.

Clocking: one clock; reset is synchronous and active-high.

- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- rs1  input  5  source register index to read
- src1  output  32  combinational contents of regs[rs1]
- modi1  output  1  combinational modified[rs1] (1 = write pending)
- rd  input  5  destination of the instruction being decoded; nonzero sets its pending bit
- reg_write  input  5  write-back register index; 0 = no write
- data_write  input  32  write-back data

Internal state must be named `regs[0:31]` (32-bit) and `modified[0:31]` (1-bit); benches probe them hierarchically.

## Operation

- Read: src1 = regs[rs1], modi1 = modified[rs1], purely combinational from stored state. No write-through bypass: a write in cycle N is visible on src1 only after that clock edge.
- rs1 = 0: src1 = 0, modi1 = 0.
- Write-back, each rising edge with rst = 0 and reg_write ≠ 0:
  - regs[reg_write] <= data_write
  - modified[reg_write] <= 0
- Mark pending, each rising edge with rst = 0 and rd ≠ 0: modified[rd] <= 1.
- Same edge, rd = reg_write ≠ 0: data is written, but modified stays/becomes 1. The set wins because a new producer has issued.
- Different rd and reg_write: both updates apply independently.
- reg_write = 0: no data write. rd = 0: no flag change. regs[0] and modified[0] are constant 0.
- Reset, rising edge with rst = 1: all regs <= 0, all modified <= 0. Reset overrides any simultaneous write or rd.

## Timing

- Read latency 0 (combinational). Write and flag update latency 1 edge.
- Reset values: every regs[i] = 0, every modified[i] = 0, so src1 = 0 and modi1 = 0 for any rs1.
- rst asserted mid-operation clears all state at the next edge, regardless of pending writes.
- Inputs held constant across multiple edges re-apply each edge. Example: reg_write held at k rewrites regs[k] and clears modified[k] every cycle unless rd = k that cycle.
- No handshakes; every input is sampled every cycle.

## Test plan

- Reset: hold rst = 1 for 2 edges with reg_write = 5, data = 0xFF. Required: all regs = 0, all modified = 0, src1 = 0 for rs1 = 5.
- Write-back sweep: on successive edges drive reg_write = i, data_write = i for i = 1..31. Required: one edge after the last write, regs[i] = i for all i, and src1 = i when rs1 = i. A write to reg 0 leaves regs[0] = 0.
- Pending set: drive rd = 1..31 on successive edges, then rd = 0. Required: modified[1..31] = 1, modi1 = 1 for each rs1 in 1..31, modified[0] = 0.
- Pending clear: after the previous scenario, drive reg_write = i, data = i for i = 1..31 with rd = 0. Required: one edge after the last write, modified[1..31] = 0 and regs[i] = i.
- Simultaneous: rd = 7, reg_write = 7, data = 0x1234 on one edge. Required: regs[7] = 0x1234, modified[7] = 1. Same edge with rd = 3, reg_write = 7: modified[3] = 1, modified[7] = 0.
- No bypass: rs1 = 9, reg_write = 9, data = 0xABCD. Required: src1 shows the old value before the edge and 0xABCD after it.
